// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder/subtractor built around one_bit_adder, LSB first.
// Define SERIAL_ADDER_SUB_EN to enable subtraction via the Sub input; otherwise the block always adds.

module one_bit_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

// Handshake: start is sampled on any rising edge while busy=0 (IDLE or DONE);
// busy is high for exactly the WIDTH RUN cycles, and done pulses for one cycle
// alongside the updated Sum/Cout/Ovf. start seen while busy=1 is dropped.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf,
  output logic [1:0]       dbg_state
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] op_a, op_b, shift_q;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] b_load;
  logic             carry_init;
  logic             bit_sum, bit_cout;
  logic             last_bit;

`ifdef SERIAL_ADDER_SUB_EN
  // Two's complement subtraction: invert B and inject a carry-in of 1.
  assign b_load     = B ^ {WIDTH{Sub}};
  assign carry_init = Sub;
`else
  logic sub_unused;
  assign sub_unused = Sub;
  assign b_load     = B;
  assign carry_init = 1'b0;
`endif

  one_bit_adder u_fa (
    .a    (op_a[0]),
    .b    (op_b[0]),
    .cin  (carry),
    .sum  (bit_sum),
    .cout (bit_cout)
  );

  assign last_bit  = (cnt == CW'(WIDTH - 1));
  assign busy      = (state == RUN);
  assign done      = (state == DONE);
  assign dbg_state = state;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_bit) state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      op_a    <= '0;
      op_b    <= '0;
      shift_q <= '0;
      carry   <= 1'b0;
      cnt     <= '0;
      Sum     <= '0;
      Cout    <= 1'b0;
      Ovf     <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            op_a  <= A;
            op_b  <= b_load;
            carry <= carry_init;
            cnt   <= '0;
          end
        end
        RUN: begin
          shift_q <= {bit_sum, shift_q[WIDTH-1:1]};
          op_a    <= op_a >> 1;
          op_b    <= op_b >> 1;
          carry   <= bit_cout;
          cnt     <= cnt + 1'b1;
          // On the MSB, carry still holds the carry into the MSB.
          if (last_bit) begin
            Sum  <= {bit_sum, shift_q[WIDTH-1:1]};
            Cout <= bit_cout;
            Ovf  <= carry ^ bit_cout;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: random and directed operations checked against an arithmetic model.
// Expectations follow SERIAL_ADDER_SUB_EN the same way the build does.

module tb_serial_adder;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         sub = 1'b0;
  logic         busy, done, cout, ovf;
  logic [W-1:0] sum;
  logic [1:0]   dbg_state;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic [W+1:0] exp_q[$];
  int           exp_cyc_q[$];

  serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .A         (a),
    .B         (b),
    .Sub       (sub),
    .busy      (busy),
    .done      (done),
    .Sum       (sum),
    .Cout      (cout),
    .Ovf       (ovf),
    .dbg_state (dbg_state)
  );

  // clock / cycle count
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // reference model: returns {cout, ovf, sum}
  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic s);
    int unsigned  xv, yv;
    logic [W-1:0] r;
    logic         c, o, eff_sub;
`ifdef SERIAL_ADDER_SUB_EN
    eff_sub = s;
`else
    eff_sub = 1'b0;
`endif
    xv = x;
    yv = y;
    if (!eff_sub) begin
      r = W'(xv + yv);
      c = ((xv + yv) >> W) != 0;
      o = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
    end else begin
      r = W'(xv - yv);
      c = (xv >= yv);
      o = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
    end
    return {c, o, r};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // driver: waits for busy=0, pulses start; optionally scoreboards the result
  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                       input bit push);
    int guard = 0;
    while (busy && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) check("busy_timeout", 32'(busy), 32'd0);
    a = x;
    b = y;
    sub = s;
    start = 1'b1;
    if (push) begin
      exp_q.push_back(model(x, y, s));
      exp_cyc_q.push_back(cyc + 1 + W);
    end
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    sub = 1'($urandom);
    check("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic drain();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  // monitor: pops and compares on every done pulse
  always @(negedge clk) begin
    if (done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        logic [W+1:0] e;
        int           ec;
        e = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        check("result", 32'({cout, ovf, sum}), 32'(e));
        check("latency", 32'(cyc), 32'(ec));
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);

    // directed cases
    issue(8'd100, 8'd55, 1'b0, 1'b1);
    issue(8'hFF, 8'h01, 1'b0, 1'b1);
    issue(8'd5, 8'd7, 1'b1, 1'b1);
    issue(8'h7F, 8'h01, 1'b0, 1'b1);
    issue(8'h80, 8'h01, 1'b1, 1'b1);
    issue(8'h00, 8'h00, 1'b1, 1'b1);
    drain();

    // start during RUN is ignored
    issue(8'd3, 8'd4, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    a = 8'd9;
    b = 8'd9;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();
    repeat (3) @(negedge clk);

    // random traffic, gap 0 gives back-to-back starts in the DONE cycle
    for (int i = 0; i < 40; i++) begin
      issue(W'($urandom), W'($urandom), 1'($urandom), 1'b1);
      repeat ($urandom_range(0, 2) * (W + 1)) @(negedge clk);
    end
    drain();

    // reset mid-RUN aborts with no done pulse
    issue(8'd1, 8'd2, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_sum", 32'(sum), 32'd0);
    repeat (W + 2) @(negedge clk);
    issue(8'd10, 8'd20, 1'b0, 1'b1);
    drain();
    check("final_sum", 32'(sum), 32'd30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial WIDTH-bit adder/subtractor for the calculator datapath. It drives a single `one_bit_adder` instance one bit per clock, LSB first, and holds the carry in a flip-flop between bits. Operands are latched on a start request, and the full result is presented with a one-cycle done pulse. It sits between operand entry and the result/display stage and is the sequential consumer of the one-bit full adder.

## Interface
- WIDTH, 8, operand and result width in bits; legal range 2..32.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request to begin an operation; sampled on rising edge.
- A  in  WIDTH  operand A, unsigned or two's complement.
- B  in  WIDTH  operand B.
- Sub  in  1  1 = compute A−B, 0 = compute A+B; latched with operands.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse when the result becomes valid.
- Sum  out  WIDTH  result register.
- Cout  out  1  carry out of the MSB; for subtraction, 1 = no borrow.
- Ovf  out  1  signed overflow: carry into MSB XOR carry out of MSB.

## Operation
- States:
  - IDLE: waiting for start.
  - RUN: shifting one bit per cycle.
  - DONE: result valid, one cycle long.
- IDLE or DONE with start=1:
  - Latch A into opA.
  - Latch B XOR {WIDTH{Sub}} into opB.
  - Set carry flop = Sub.
  - Set bit counter = 0.
  - Go to RUN.
- IDLE or DONE with start=0: DONE → IDLE; IDLE stays in IDLE.
- RUN, each cycle:
  - Feed opA[0], opB[0] and the carry flop into `one_bit_adder`.
  - Shift the adder's Sum bit into the MSB of the internal shift register.
  - Shift opA and opB right by one.
  - Load the carry flop with the adder's Cout.
  - Increment the counter.
- RUN, on the bit where counter = WIDTH−1:
  - Load Sum with the completed shift value.
  - Load Cout with the adder's Cout.
  - Load Ovf with (carry into MSB) XOR (adder Cout).
  - Go to DONE.
- start while in RUN is ignored; no queuing.
- Sum, Cout and Ovf change only at completion and hold their value until the next completion or reset.
- Arithmetic is modulo 2^WIDTH; no saturation.

## Timing
- Reset values: state IDLE; busy=0, done=0, Sum=0, Cout=0, Ovf=0; internal registers 0.
- rst asserted in any state, including mid-RUN: takes effect at the next edge, aborts the operation, produces no done pulse, and clears the result registers.
- Edge 0: start sampled → busy=1 from edge 0.
- Edges 1..WIDTH: bit processing.
- At edge WIDTH: Sum, Cout, Ovf are updated and done=1; busy=0 from that edge.
- Latency from start edge to result valid: WIDTH cycles.
- done lasts exactly one cycle unless start is asserted in that DONE cycle. In that case a new operation begins, done deasserts, and busy reasserts at the next edge.
- Back-to-back throughput: one result every WIDTH+1 cycles.
- A, B and Sub need to be stable only at the start edge.

## Configuration
- SERIAL_ADDER_SUB_EN defined:
  - Subtraction supported as described.
  - Sub input is latched and used.
- SERIAL_ADDER_SUB_EN undefined:
  - Sub port is still present but ignored.
  - opB = B and the carry flop initialises to 0, so the block always adds.
  - The XOR inversion logic is not synthesised.

## Test plan
- WIDTH=8, A=100, B=55, Sub=0, start pulsed → done exactly 8 edges after the start edge; Sum=155, Cout=0, Ovf=1 (signed 100+55 overflows).
- A=8'hFF, B=8'h01, Sub=0 → Sum=8'h00, Cout=1, Ovf=0.
- A=5, B=7, Sub=1 (macro defined) → Sum=8'hFE, Cout=0, Ovf=0.
- Same stimulus with the macro undefined → Sum=12, Cout=0.
- A=8'h7F, B=8'h01, Sub=0 → Sum=8'h80, Ovf=1.
- start A=3, B=4; start pulsed again 3 cycles later with A=9, B=9 → first operation completes with Sum=7 and the second start is ignored.
- Start A=1, B=2 (Sum=3); rst asserted at edge 4; start A=10, B=20 pulsed after reset:
  - After reset: Sum=0, busy=0, and no done pulse for the aborted operation.
  - New operation completes with Sum=30 and the correct 8-cycle latency.
